// File: rtl/el2_ifu_aligner_seq.sv
// Halfword aligner: splits 32-bit fetch words into 16/32-bit instructions; outputs combinational from state, 0 latency.
// fetch_ready depends only on FIFO fill (count<=2); a stalled consumer fills the FIFO and then stops fetch.
module el2_ifu_aligner_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [30:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic [15:0] cmp_din,
  input  logic [31:0] cmp_dout,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [30:0] inst_pc,
  output logic        inst_c,
  output logic        inst_illegal
);

  localparam logic [0:0] NORM = 1'b0;
  localparam logic [0:0] SKIP = 1'b1;

  // hw_q[15:0] is the head; unused slots are kept at zero so shifts fill cleanly
  logic [63:0]  hw_q;
  logic [2:0]   count_q;
  logic [30:0]  pc_q;
  logic [0:0]   state_q;

  logic         head32;
  logic         push;
  logic         pop;
  logic [1:0]   pop_n;
  logic [1:0]   push_n;
  logic [2:0]   rem;
  logic [31:0]  push_dat;
  logic [127:0] push_vec;
  logic [63:0]  hw_nxt;

  assign head32       = (hw_q[1:0] == 2'b11);
  assign fetch_ready  = (count_q <= 3'd2) && !flush && !rst;
  assign inst_valid   = !flush && !rst && (head32 ? (count_q >= 3'd2) : (count_q >= 3'd1));
  assign cmp_din      = hw_q[15:0];
  assign inst         = head32 ? hw_q[31:0] : cmp_dout;
  assign inst_c       = !head32;
  assign inst_illegal = !head32 && (cmp_dout == 32'h0);
  assign inst_pc      = pc_q;

  assign push   = fetch_valid && fetch_ready;
  assign pop    = inst_valid && inst_ready;
  assign pop_n  = pop ? (head32 ? 2'd2 : 2'd1) : 2'd0;
  assign push_n = push ? ((state_q == SKIP) ? 2'd1 : 2'd2) : 2'd0;
  assign rem    = count_q - {1'b0, pop_n};

  // After a misaligned redirect only the upper halfword of the first word is wanted
  assign push_dat = (state_q == SKIP) ? {16'h0, fetch_data[31:16]} : fetch_data;

  always_comb begin
    push_vec = 128'h0;
    if (push) push_vec = {96'h0, push_dat} << {rem, 4'b0000};
    hw_nxt = (hw_q >> {pop_n, 4'b0000}) | push_vec[63:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q    <= 64'h0;
      count_q <= 3'd0;
      pc_q    <= 31'h0;
      state_q <= NORM;
    end else if (flush) begin
      hw_q    <= 64'h0;
      count_q <= 3'd0;
      pc_q    <= flush_pc;
      state_q <= flush_pc[0] ? SKIP : NORM;
    end else begin
      hw_q    <= hw_nxt;
      count_q <= rem + {1'b0, push_n};
      pc_q    <= pc_q + {29'h0, pop_n};
      if (push) state_q <= NORM;
    end
  end

endmodule

// File: tb/tb_el2_ifu_aligner_seq.sv
// Bench for el2_ifu_aligner_seq: halfword-queue reference model plus directed literal checks and random traffic.
module tb_el2_ifu_aligner_seq;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [30:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [15:0] cmp_din;
  logic [31:0] cmp_dout;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [30:0] inst_pc;
  logic        inst_c;
  logic        inst_illegal;

  int checks = 0;
  int errors = 0;

  el2_ifu_aligner_seq dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .cmp_din(cmp_din), .cmp_dout(cmp_dout),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .inst_c(inst_c), .inst_illegal(inst_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in decompressor: a few real expansions, zero for illegal patterns, otherwise a nonzero token
  function automatic logic [31:0] expand(input logic [15:0] h);
    if (h == 16'h0000) return 32'h0;
    if (h == 16'h0505) return 32'h00150513;
    if (h == 16'h0001) return 32'h00000013;
    if (h[15:12] == 4'hF && h[1:0] == 2'b00) return 32'h0;
    return {~h, h};
  endfunction

  assign cmp_dout = expand(cmp_din);

  // Reference model: plain queue of buffered halfwords
  logic [15:0] q[$];
  logic [30:0] mpc = 31'h0;
  bit          mskip = 1'b0;
  bit          exp_rdy;
  bit          exp_vld;
  bit          exp_h32;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] e;
    exp_h32 = (q.size() > 0) && (q[0][1:0] == 2'b11);
    exp_rdy = (q.size() <= 2) && !rst && !flush;
    exp_vld = !rst && !flush && ((q.size() >= 2) || (q.size() == 1 && !exp_h32));
    chk("fetch_ready", {31'h0, fetch_ready}, {31'h0, exp_rdy});
    chk("inst_valid", {31'h0, inst_valid}, {31'h0, exp_vld});
    chk("cmp_din", {16'h0, cmp_din}, (q.size() > 0) ? {16'h0, q[0]} : 32'h0);
    if (exp_vld) begin
      e = exp_h32 ? {q[1], q[0]} : expand(q[0]);
      chk("inst", inst, e);
      chk("inst_pc", {1'b0, inst_pc}, {1'b0, mpc});
      chk("inst_c", {31'h0, inst_c}, {31'h0, !exp_h32});
      chk("inst_illegal", {31'h0, inst_illegal}, {31'h0, (!exp_h32 && e == 32'h0)});
    end
  endtask

  task automatic model_update();
    int n;
    if (rst) begin
      q.delete(); mpc = 31'h0; mskip = 1'b0;
    end else if (flush) begin
      q.delete(); mpc = flush_pc; mskip = flush_pc[0];
    end else begin
      if (exp_vld && inst_ready) begin
        n = exp_h32 ? 2 : 1;
        repeat (n) void'(q.pop_front());
        mpc = mpc + 31'(n);
      end
      if (fetch_valid && exp_rdy) begin
        if (!mskip) q.push_back(fetch_data[15:0]);
        q.push_back(fetch_data[31:16]);
        mskip = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic f, input logic [30:0] fp,
                      input logic fv, input logic [31:0] fd, input logic ir);
    rst = r; flush = f; flush_pc = fp; fetch_valid = fv; fetch_data = fd; inst_ready = ir;
    #1;
    compare();
  endtask

  task automatic adv();
    model_update();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] fd;
    rst = 1'b1; flush = 1'b0; flush_pc = 31'h0; fetch_valid = 1'b0;
    fetch_data = 32'h0; inst_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset behaviour and first cycle out of reset
    step(1, 0, 0, 1, 32'h0, 1);
    chk("rst_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("post_rst_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("post_rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    adv();

    // Mixed 16/32-bit stream, 32-bit instruction straddling two fetch words
    step(0, 1, 31'h800, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'h05130505, 0); adv();
    step(0, 0, 0, 1, 32'h00010015, 1);
    chk("seq1_inst", inst, 32'h00150513);
    chk("seq1_pc", {1'b0, inst_pc}, 32'h800);
    chk("seq1_c", {31'h0, inst_c}, 32'h1);
    adv();
    step(0, 0, 0, 0, 32'h0, 1);
    chk("seq2_inst", inst, 32'h00150513);
    chk("seq2_pc", {1'b0, inst_pc}, 32'h801);
    chk("seq2_c", {31'h0, inst_c}, 32'h0);
    adv();
    step(0, 0, 0, 0, 32'h0, 1);
    chk("seq3_inst", inst, 32'h00000013);
    chk("seq3_pc", {1'b0, inst_pc}, 32'h803);
    chk("seq3_c", {31'h0, inst_c}, 32'h1);
    adv();

    // Misaligned redirect drops the lower halfword
    step(0, 1, 31'h1001, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'hAAAABBBB, 0); adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("skip_cmp_din", {16'h0, cmp_din}, 32'hAAAA);
    chk("skip_pc", {1'b0, inst_pc}, 32'h1001);
    chk("skip_valid", {31'h0, inst_valid}, 32'h1);
    adv();

    // Full FIFO stops fetch; one 32-bit pop reopens it
    step(0, 1, 31'h100, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'h00130013, 0); adv();
    step(0, 0, 0, 1, 32'h00130013, 0); adv();
    step(0, 0, 0, 1, 32'h00130013, 0);
    chk("full_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    adv();
    step(0, 0, 0, 0, 32'h0, 1);
    chk("full_pop_c", {31'h0, inst_c}, 32'h0);
    adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("reopen_fetch_ready", {31'h0, fetch_ready}, 32'h1);
    chk("reopen_pc", {1'b0, inst_pc}, 32'h102);
    adv();

    // Illegal compressed encoding still pops one halfword
    step(0, 1, 31'h200, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'h00000000, 0); adv();
    step(0, 0, 0, 0, 32'h0, 1);
    chk("ill_valid", {31'h0, inst_valid}, 32'h1);
    chk("ill_c", {31'h0, inst_c}, 32'h1);
    chk("ill_flag", {31'h0, inst_illegal}, 32'h1);
    adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("ill_next_pc", {1'b0, inst_pc}, 32'h201);
    adv();

    // Flush beats push and pop with three halfwords buffered
    step(0, 1, 31'h11, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'h00010001, 0); adv();
    step(0, 0, 0, 1, 32'h00010001, 0); adv();
    step(0, 1, 31'h40, 1, 32'h12345678, 1);
    chk("flush_fetch_ready", {31'h0, fetch_ready}, 32'h0);
    chk("flush_inst_valid", {31'h0, inst_valid}, 32'h0);
    adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("flush_after_valid", {31'h0, inst_valid}, 32'h0);
    chk("flush_after_pc", {1'b0, inst_pc}, 32'h40);
    chk("flush_after_cmp", {16'h0, cmp_din}, 32'h0);
    adv();

    // Reset while a 32-bit head waits for its upper half
    step(0, 1, 31'h20, 0, 32'h0, 0); adv();
    step(0, 0, 0, 1, 32'h00030001, 1); adv();
    step(0, 0, 0, 0, 32'h0, 1); adv();
    step(0, 0, 0, 0, 32'h0, 1);
    chk("straddle_wait_valid", {31'h0, inst_valid}, 32'h0);
    adv();
    step(1, 1, 31'h55, 1, 32'hFFFFFFFF, 1); adv();
    step(0, 0, 0, 0, 32'h0, 0);
    chk("rst_mid_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_mid_pc", {1'b0, inst_pc}, 32'h0);
    chk("rst_mid_cmp", {16'h0, cmp_din}, 32'h0);
    adv();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      fd = $urandom;
      if ($urandom_range(0, 7) == 0) fd[15:0] = 16'h0;
      if ($urandom_range(0, 7) == 0) fd[31:16] = 16'h0;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0) ? (31'h7FFFFFFF - 31'($urandom_range(0, 3))) : 31'($urandom),
           ($urandom_range(0, 9) < 7), fd, ($urandom_range(0, 9) < 6));
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
